// File: rtl/gerador_passos.sv
// gerador_passos: steps a downstream up/down counter toward a target with spaced single-cycle pulses
module gerador_passos #(
    parameter int VALOR_INICIAL = 106,
    parameter int INTERVALO     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] alvo,
    input  logic       iniciar,
    input  logic       abortar,
    output logic       acrescer,
    output logic       decrecer,
    output logic [7:0] espelho,
    output logic       ocupado,
    output logic       pronto
);
    typedef enum logic [1:0] {OCIOSO, PASSO, ESPERA, FIM} estado_t;
    estado_t    estado_q;
    logic [7:0] espelho_q, alvo_q, espera_q;
    logic       subida_q, acrescer_q, decrecer_q, ocupado_q, pronto_q;
    logic [7:0] espelho_d;
    assign espelho_d = subida_q ? espelho_q + 8'd1 : espelho_q - 8'd1;
    assign acrescer  = acrescer_q;
    assign decrecer  = decrecer_q;
    assign espelho   = espelho_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    // Move FSM; every output is set on the edge that enters the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            espelho_q  <= 8'(VALOR_INICIAL);
            alvo_q     <= 8'(VALOR_INICIAL);
            espera_q   <= '0;
            subida_q   <= 1'b0;
            acrescer_q <= 1'b0;
            decrecer_q <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            acrescer_q <= 1'b0;
            decrecer_q <= 1'b0;
            pronto_q   <= 1'b0;
            case (estado_q)
                OCIOSO: if (iniciar) begin
                    alvo_q   <= alvo;
                    subida_q <= alvo > espelho_q;
                    if (alvo == espelho_q) begin
                        estado_q <= FIM;
                        pronto_q <= 1'b1;
                    end else begin
                        estado_q   <= PASSO;
                        ocupado_q  <= 1'b1;
                        acrescer_q <= alvo > espelho_q;
                        decrecer_q <= alvo < espelho_q;
                    end
                end
                PASSO: begin
                    espelho_q <= espelho_d;
                    if (abortar || espelho_d == alvo_q) begin
                        estado_q  <= FIM;
                        ocupado_q <= 1'b0;
                        pronto_q  <= 1'b1;
                    end else begin
                        estado_q <= ESPERA;
                        espera_q <= 8'(INTERVALO - 2);
                    end
                end
                ESPERA: if (abortar) begin
                    estado_q  <= FIM;
                    ocupado_q <= 1'b0;
                    pronto_q  <= 1'b1;
                end else if (espera_q == 8'd0) begin
                    estado_q   <= PASSO;
                    acrescer_q <= subida_q;
                    decrecer_q <= !subida_q;
                end else begin
                    espera_q <= espera_q - 8'd1;
                end
                FIM: estado_q <= OCIOSO;
                default: estado_q <= OCIOSO;
            endcase
        end
    end
endmodule

// File: tb/tb_gerador_passos.sv
// tb_gerador_passos: directed scenarios with an event scoreboard on pulses and pronto
module tb_gerador_passos;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] alvo_a, alvo_b, esp_a, esp_b;
    logic       iniciar_a, iniciar_b, abortar_a, abortar_b;
    logic       acr_a, dec_a, ocup_a, pronto_a;
    logic       acr_b, dec_b, ocup_b, pronto_b;

    typedef struct {
        int         ciclo;
        logic [2:0] tipo;
        logic [7:0] esp;
    } evento_t;

    evento_t fila[$];
    int      errors = 0, checks = 0, cyc = 0, base = 0, de = 1, ate = 0;
    int      base_b = 0, last_b = 0, nb = 0;
    logic    fim_b = 1'b0;

    gerador_passos u_a (
        .clk(clk), .rst(rst), .alvo(alvo_a), .iniciar(iniciar_a), .abortar(abortar_a),
        .acrescer(acr_a), .decrecer(dec_a), .espelho(esp_a), .ocupado(ocup_a), .pronto(pronto_a)
    );

    gerador_passos #(.VALOR_INICIAL(0), .INTERVALO(2)) u_b (
        .clk(clk), .rst(rst), .alvo(alvo_b), .iniciar(iniciar_b), .abortar(abortar_b),
        .acrescer(acr_b), .decrecer(dec_b), .espelho(esp_b), .ocupado(ocup_b), .pronto(pronto_b)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample both instances at the falling edge, then advance past the rising edge
    task automatic ciclo();
        logic [2:0] ev;
        evento_t    e;
        @(negedge clk);
        ev = {acr_a, dec_a, pronto_a};
        verifica("exclusivo", 32'(acr_a & dec_a), 0);
        verifica("ocupado", 32'(ocup_a), 32'(cyc - base >= de && cyc - base <= ate));
        if (ev != 3'b000) begin
            if (fila.size() == 0) begin
                verifica("inesperado", 32'(ev), 0);
            end else begin
                e = fila.pop_front();
                verifica("ev_ciclo", cyc - base, e.ciclo);
                verifica("ev_tipo", 32'(ev), 32'(e.tipo));
                verifica("ev_esp", 32'(esp_a), 32'(e.esp));
            end
        end
        verifica("b_dec", 32'(dec_b), 0);
        if (acr_b) begin
            verifica("b_espaco", cyc, nb == 0 ? base_b + 1 : last_b + 2);
            nb++;
            last_b = cyc;
        end
        if (pronto_b) fim_b = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic correr(input int n);
        repeat (n) ciclo();
    endtask

    task automatic reiniciar();
        rst = 1'b1;
        ciclo();
        rst = 1'b0;
        ciclo();
    endtask

    task automatic comecar(input logic [7:0] v);
        alvo_a    = v;
        iniciar_a = 1'b1;
        base      = cyc;
        ciclo();
        iniciar_a = 1'b0;
    endtask

    task automatic esperado(input int c, input logic [2:0] t, input logic [7:0] v);
        evento_t e;
        e.ciclo = c;
        e.tipo  = t;
        e.esp   = v;
        fila.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        alvo_a = 8'd0; alvo_b = 8'd0;
        iniciar_a = 1'b0; iniciar_b = 1'b0;
        abortar_a = 1'b0; abortar_b = 1'b0;
        #2;
        verifica("rst_esp", 32'(esp_a), 106);
        verifica("rst_saidas", 32'({acr_a, dec_a, ocup_a, pronto_a}), 0);
        verifica("rst_alvo_reg", 32'(u_a.alvo_q), 106);
        verifica("rst_esp_b", 32'(esp_b), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        correr(5);
        verifica("idle_esp", 32'(esp_a), 106);

        esperado(1, 3'b010, 8'd106);
        esperado(5, 3'b010, 8'd105);
        esperado(6, 3'b001, 8'd104);
        de = 1; ate = 5;
        comecar(8'd104);
        correr(8);
        verifica("desce_fila", fila.size(), 0);
        verifica("desce_esp", 32'(esp_a), 104);

        reiniciar();
        esperado(1, 3'b100, 8'd106);
        esperado(5, 3'b100, 8'd107);
        esperado(9, 3'b100, 8'd108);
        esperado(10, 3'b001, 8'd109);
        de = 1; ate = 9;
        comecar(8'd109);
        correr(12);
        verifica("sobe_fila", fila.size(), 0);
        verifica("sobe_esp", 32'(esp_a), 109);

        reiniciar();
        esperado(1, 3'b001, 8'd106);
        de = 1; ate = 0;
        comecar(8'd106);
        correr(4);
        verifica("igual_fila", fila.size(), 0);

        reiniciar();
        esperado(1, 3'b100, 8'd106);
        esperado(4, 3'b001, 8'd107);
        de = 1; ate = 3;
        comecar(8'd200);
        correr(2);
        iniciar_a = 1'b1; alvo_a = 8'd0; abortar_a = 1'b1;
        ciclo();
        iniciar_a = 1'b0; abortar_a = 1'b0;
        correr(5);
        verifica("aborta_fila", fila.size(), 0);
        verifica("aborta_alvo_reg", 32'(u_a.alvo_q), 200);
        verifica("aborta_esp", 32'(esp_a), 107);

        esperado(1, 3'b100, 8'd107);
        esperado(2, 3'b001, 8'd108);
        de = 1; ate = 1;
        abortar_a = 1'b1;
        comecar(8'd200);
        ciclo();
        abortar_a = 1'b0;
        correr(4);
        verifica("aborta_passo_fila", fila.size(), 0);
        verifica("aborta_passo_esp", 32'(esp_a), 108);

        reiniciar();
        esperado(1, 3'b100, 8'd106);
        de = 1; ate = 2;
        comecar(8'd110);
        correr(2);
        #2;
        rst = 1'b1;
        #1;
        verifica("rst_espera_esp", 32'(esp_a), 106);
        verifica("rst_espera_ocup", 32'(ocup_a), 0);
        ciclo();
        rst = 1'b0;
        correr(10);
        verifica("rst_espera_fila", fila.size(), 0);
        verifica("rst_espera_esp_fim", 32'(esp_a), 106);

        alvo_b = 8'd255;
        iniciar_b = 1'b1;
        base_b = cyc;
        nb = 0;
        fim_b = 1'b0;
        ciclo();
        iniciar_b = 1'b0;
        for (int i = 0; i < 700 && !fim_b; i++) ciclo();
        verifica("rampa_fim", 32'(fim_b), 1);
        verifica("rampa_pulsos", nb, 255);
        verifica("rampa_esp", 32'(esp_b), 255);
        correr(4);
        verifica("rampa_sem_volta", 32'(esp_b), 255);
        verifica("rampa_ocup", 32'(ocup_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gerador_passos.md
GERADOR_PASSOS -- requirements
Module: gerador_passos

Interface
REQ-001 Parameter VALOR_INICIAL, default 106: power-on value of the mirrored counter.
REQ-002 Parameter INTERVALO, default 4, legal range 2..255: clock cycles from one step pulse to the next.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 alvo  input  8  requested target value, unsigned; sampled only on an accepted iniciar.
REQ-006 iniciar  input  1  one-cycle start request.
REQ-007 abortar  input  1  stop request; level-sampled each cycle.
REQ-008 acrescer  output  1  increment pulse to the downstream up/down counter.
REQ-009 decrecer  output  1  decrement pulse to the downstream up/down counter.
REQ-010 espelho  output  8  mirror of the downstream counter value.
REQ-011 ocupado  output  1  high while a move is in progress.
REQ-012 pronto  output  1  one-cycle completion pulse.

Function
REQ-013 The block SHALL drive a downstream counter from espelho to alvo with single-cycle acrescer/decrecer pulses, keeping espelho equal to the downstream counter value.
REQ-014 All outputs SHALL be registered; acrescer and decrecer SHALL never be high in the same cycle.
REQ-015 The FSM SHALL have states OCIOSO, PASSO, ESPERA and FIM; ocupado SHALL be high in PASSO and ESPERA only.
REQ-016 In OCIOSO, iniciar=1 SHALL latch alvo into alvo_reg; if alvo equals espelho, next state is FIM, otherwise PASSO.
REQ-017 In OCIOSO, iniciar=0 SHALL hold all state.
REQ-018 In PASSO, for exactly one cycle, acrescer=1 if alvo_reg>espelho, else decrecer=1; espelho SHALL change by +1 or -1 at the edge that ends PASSO.
REQ-019 Direction SHALL be chosen by unsigned comparison; the block SHALL never use 8-bit wrap-around, so an 8-bit move takes |alvo-espelho| steps, at most 255.
REQ-020 After PASSO: if the updated espelho equals alvo_reg, next state is FIM, otherwise ESPERA.
REQ-021 ESPERA SHALL last INTERVALO-1 cycles, then go to PASSO, so consecutive pulse rising edges are exactly INTERVALO cycles apart.
REQ-022 In FIM, pronto SHALL be 1 for exactly one cycle; the next state is OCIOSO.
REQ-023 iniciar while ocupado=1 or in FIM SHALL be ignored, and alvo_reg SHALL be unchanged.
REQ-024 abortar=1 sampled in PASSO or ESPERA SHALL force FIM at the next edge; a pulse already in progress in PASSO completes and is counted in espelho.
REQ-025 abortar in OCIOSO or FIM SHALL have no effect.
REQ-026 If iniciar and abortar are both high in OCIOSO, iniciar SHALL take effect and abortar SHALL be ignored.
REQ-027 Latency from iniciar: the first pulse is high in the cycle after the accepting edge; pronto follows the final PASSO cycle directly.

Reset
REQ-028 While rst=1, regardless of clk: state=OCIOSO, espelho=VALOR_INICIAL, alvo_reg=VALOR_INICIAL, acrescer=0, decrecer=0, ocupado=0, pronto=0.
REQ-029 Reset mid-move SHALL abandon the move with no further pulses; espelho returns to VALOR_INICIAL, matching a downstream counter reset together with this block.

Verification
REQ-030 Bench SHALL cover the following scenarios, with INTERVALO=4 and VALOR_INICIAL=106 unless stated.
- Assert rst mid-cycle -> outputs go immediately to espelho=106 and all others 0; no activity after release with iniciar=0.
- alvo=109 with iniciar at cycle 0 -> acrescer high in cycles 1, 5, 9; espelho 107/108/109; pronto high in cycle 10; ocupado high in cycles 1-9.
- alvo=104 -> decrecer high in cycles 1 and 5; espelho ends at 104; pronto in cycle 6; acrescer never high.
- alvo=106 -> no pulses; ocupado stays 0; pronto high in cycle 1.
- alvo=200, then iniciar with alvo=0 at cycle 3 (ignored), then abortar at cycle 3 -> exactly one acrescer pulse; espelho=107; pronto in cycle 4; alvo_reg still 200.
- alvo=255 from 0 with INTERVALO=2 -> 255 acrescer pulses every 2 cycles; espelho=255; no wrap. Plus: rst during ESPERA -> no further pulses and espelho=106.
